// File: rtl/regfile_dump_reader_pkg.sv
// Shared definitions for the register-file dump reader.
// Holds the dump FSM state encoding and the fixed byte and address widths.
// No ports. Imported by the interface, the serializer and the top.
package regfile_dump_reader_pkg;

  localparam int BYTE_WIDTH    = 8;
  localparam int RF_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Bus bundle between the dump reader, the regfile debug read port and the TX path.
// Signals: rf_addr/rf_data form the regfile read port; tx_data/tx_valid/tx_ready form the byte stream.
// Modports: master = dump reader side, slave = regfile + transmitter side.
interface regfile_dump_reader_if #(
  parameter int DATA_WIDTH = 32
) ();
  import regfile_dump_reader_pkg::*;

  logic [RF_ADDR_WIDTH-1:0] rf_addr;
  logic [DATA_WIDTH-1:0]    rf_data;
  logic [BYTE_WIDTH-1:0]    tx_data;
  logic                     tx_valid;
  logic                     tx_ready;

  modport master (
    output rf_addr,
    input  rf_data,
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  rf_addr,
    output rf_data,
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/regfile_dump_reader_word_serializer.sv
// Purpose: holds one register word and emits it LSB-first as bytes over valid/ready.
// Latency: tx_valid rises the cycle after i_load; one byte per accepted handshake.
// Backpressure: valid and data hold until i_tx_ready; never retracted.
// Ports: clk, i_rst (async, active-high), i_load/i_word (capture), o_tx_data/o_tx_valid/i_tx_ready
// (byte stream), o_word_done (handshake of the final byte of the word, combinational).
module regfile_dump_reader_word_serializer
  import regfile_dump_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_word,
  output logic [BYTE_WIDTH-1:0] o_tx_data,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready,
  output logic                  o_word_done
);

  localparam int BYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BYTES - 1);

  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  valid_q, valid_d;
  logic                  fire;
  logic                  last_byte;

  assign fire        = valid_q & i_tx_ready;
  assign last_byte   = (cnt_q == LAST_IDX);
  assign o_word_done = fire & last_byte;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (i_load) begin
      shreg_d = i_word;
      cnt_d   = '0;
      valid_d = 1'b1;
    end else if (fire) begin
      // Next byte moves into the low lane; the emptied top fills with zeros.
      shreg_d = shreg_q >> BYTE_WIDTH;
      if (last_byte) begin
        cnt_d   = '0;
        valid_d = 1'b0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign o_tx_data  = shreg_q[BYTE_WIDTH-1:0];
  assign o_tx_valid = valid_q;

endmodule

// File: rtl/regfile_dump_reader.sv
// Purpose: on i_start, walks regfile addresses 0..NREGS-1 and streams each word LSB-first as bytes.
// Latency: first byte valid two cycles after i_start; one LOAD cycle between words; o_done one cycle after the last handshake.
// Backpressure: bus.tx_ready low stalls indefinitely, byte held stable, nothing lost or repeated.
// Ports: clk, i_rst (async, active-high), i_start (sampled in IDLE only), o_busy (not IDLE),
// o_done (one-cycle pulse), bus (master: rf_addr/rf_data read port, tx_data/tx_valid/tx_ready stream).
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NREGS      = 32
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_done,
  regfile_dump_reader_if.master bus
);

  if ((DATA_WIDTH % BYTE_WIDTH) != 0 || DATA_WIDTH < BYTE_WIDTH || NREGS < 1 || NREGS > 32) begin : g_param_chk
    $error("regfile_dump_reader: DATA_WIDTH must be a nonzero multiple of 8 and NREGS in 1..32");
  end

  localparam logic [RF_ADDR_WIDTH-1:0] LAST_ADDR = RF_ADDR_WIDTH'(NREGS - 1);

  state_e                   state_q;
  logic [RF_ADDR_WIDTH-1:0] rf_addr_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     word_done;

  regfile_dump_reader_word_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ser (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_load      (state_q == ST_LOAD),
    .i_word      (bus.rf_data),
    .o_tx_data   (bus.tx_data),
    .o_tx_valid  (bus.tx_valid),
    .i_tx_ready  (bus.tx_ready),
    .o_word_done (word_done)
  );

  // busy/done are registered alongside the state so they change on the same edge as it.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      rf_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            rf_addr_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          state_q <= ST_SEND;
        end
        ST_SEND: begin
          if (word_done) begin
            if (rf_addr_q == LAST_ADDR) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              rf_addr_q <= rf_addr_q + RF_ADDR_WIDTH'(1);
              state_q   <= ST_LOAD;
            end
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.rf_addr = rf_addr_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: default 32x32 instance plus a 4x16 instance.
// Expected byte streams come from the register contents by plain word/byte arithmetic.
module tb_regfile_dump_reader;

  localparam int MAXC = 2000;

  logic clk = 1'b0;
  logic i_rst;
  logic i_start, o_busy, o_done;
  logic start16, busy16, done16;

  regfile_dump_reader_if #(.DATA_WIDTH(32)) bus ();
  regfile_dump_reader_if #(.DATA_WIDTH(16)) bus16 ();

  logic [31:0] rf_mem [32];
  logic [15:0] rf16 [4];

  assign bus.rf_data   = rf_mem[bus.rf_addr];
  assign bus16.rf_data = rf16[bus16.rf_addr[1:0]];

  regfile_dump_reader #(.DATA_WIDTH(32), .NREGS(32)) dut (
    .clk     (clk),
    .i_rst   (i_rst),
    .i_start (i_start),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .bus     (bus)
  );

  regfile_dump_reader #(.DATA_WIDTH(16), .NREGS(4)) dut16 (
    .clk     (clk),
    .i_rst   (i_rst),
    .i_start (start16),
    .o_busy  (busy16),
    .o_done  (done16),
    .bus     (bus16)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] got[$];
  logic [7:0] exp_b[$];
  logic [4:0] got_addr[$];
  int         done_cs[$];
  logic       busy_tr [MAXC];
  int         stall_bad;
  int         first_valid;
  int         last_hs;

  task automatic fill_rf(input bit pattern);
    for (int n = 0; n < 32; n++) rf_mem[n] = pattern ? (32'h11223300 + 32'(n)) : $urandom;
    rf_mem[0] = 32'h0;
  endtask

  // Reference stream: registers ascending, each word least significant byte first.
  task automatic build_exp();
    exp_b.delete();
    for (int r = 0; r < 32; r++)
      for (int b = 0; b < 4; b++) exp_b.push_back(8'((rf_mem[r] >> (8 * b)) & 32'hFF));
  endtask

  // Drives one or more dumps and records what the DUT emits; judging happens in the tests.
  task automatic run_dump(input int rmode, input bit spam, input int ndumps);
    logic r, prev_stall;
    logic [7:0] prev_data;
    got.delete(); got_addr.delete(); done_cs.delete();
    stall_bad = 0; first_valid = -1; last_hs = -1;
    prev_stall = 1'b0; prev_data = 8'h0;
    for (int c = 0; c < MAXC; c++) busy_tr[c] = 1'b0;
    @(negedge clk);
    i_start = 1'b1;
    for (int c = 0; c < MAXC; c++) begin
      @(negedge clk);
      busy_tr[c] = o_busy;
      if (o_done === 1'b1) done_cs.push_back(c);
      if (done_cs.size() >= ndumps) i_start = 1'b0;
      else if (ndumps > 1)          i_start = 1'b1;
      else if (spam)                i_start = 1'($urandom_range(0, 1));
      else                          i_start = 1'b0;
      if (prev_stall && (bus.tx_valid !== 1'b1 || bus.tx_data !== prev_data)) stall_bad++;
      if (bus.tx_valid === 1'b1 && first_valid < 0) first_valid = c;
      case (rmode)
        0:       r = 1'b1;
        1:       r = (c % 2 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      bus.tx_ready = r;
      if (bus.tx_valid === 1'b1 && r) begin
        got.push_back(bus.tx_data);
        got_addr.push_back(bus.rf_addr);
        last_hs = c;
      end
      prev_stall = (bus.tx_valid === 1'b1) && !r;
      prev_data  = bus.tx_data;
      if (done_cs.size() >= ndumps && c >= done_cs[ndumps-1] + 3) break;
    end
    bus.tx_ready = 1'b0;
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_start = 1'b1; start16 = 1'b0;
    bus.tx_ready = 1'b1; bus16.tx_ready = 1'b0;
    fill_rf(1'b1);
    for (int n = 0; n < 4; n++) rf16[n] = 16'h0;
    #3;
    total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", bus.tx_valid); end
    total++; if (bus.tx_data !== 8'h00) begin bad++; $display("FAIL rst_data got=%h want=00", bus.tx_data); end
    total++; if (bus.rf_addr !== 5'd0) begin bad++; $display("FAIL rst_addr got=%0d want=0", bus.rf_addr); end
    total++; if (o_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", o_done); end
    repeat (2) @(negedge clk);
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rst_busy_start got=%b want=0", o_busy); end
    i_start = 1'b0; bus.tx_ready = 1'b0;
    i_rst = 1'b0;
    @(negedge clk);
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", o_busy); end
  endtask

  task automatic test_basic();
    int d0;
    fill_rf(1'b1);
    build_exp();
    run_dump(0, 1'b0, 1);
    d0 = (done_cs.size() > 0) ? done_cs[0] : 0;
    total++; if (got.size() != 128) begin bad++; $display("FAIL basic_count got=%0d want=128", got.size()); end
    for (int i = 0; i < got.size() && i < 128; i++) begin
      total++; if (got[i] !== exp_b[i]) begin bad++; $display("FAIL basic_byte[%0d] got=%h want=%h", i, got[i], exp_b[i]); end
      total++; if (got_addr[i] !== 5'(i / 4)) begin bad++; $display("FAIL basic_addr[%0d] got=%0d want=%0d", i, got_addr[i], i / 4); end
    end
    total++; if (done_cs.size() != 1) begin bad++; $display("FAIL basic_done_pulses got=%0d want=1", done_cs.size()); end
    total++; if (d0 != 160) begin bad++; $display("FAIL basic_done_cycle got=%0d want=160", d0); end
    total++; if (d0 != last_hs + 1) begin bad++; $display("FAIL basic_done_after_last got=%0d want=%0d", d0, last_hs + 1); end
    total++; if (first_valid != 1) begin bad++; $display("FAIL basic_first_valid got=%0d want=1", first_valid); end
    total++; if (busy_tr[0] !== 1'b1) begin bad++; $display("FAIL basic_busy_load got=%b want=1", busy_tr[0]); end
    total++; if (busy_tr[d0] !== 1'b1) begin bad++; $display("FAIL basic_busy_done got=%b want=1", busy_tr[d0]); end
    total++; if (busy_tr[d0+1] !== 1'b0) begin bad++; $display("FAIL basic_busy_after got=%b want=0", busy_tr[d0+1]); end
    total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_after got=%b want=0", bus.tx_valid); end
    total++; if (bus.rf_addr !== 5'd31) begin bad++; $display("FAIL basic_addr_hold got=%0d want=31", bus.rf_addr); end
  endtask

  task automatic test_stall();
    fill_rf(1'b0);
    build_exp();
    run_dump(1, 1'b0, 1);
    total++; if (got.size() != 128) begin bad++; $display("FAIL stall_count got=%0d want=128", got.size()); end
    for (int i = 0; i < got.size() && i < 128; i++) begin
      total++; if (got[i] !== exp_b[i]) begin bad++; $display("FAIL stall_byte[%0d] got=%h want=%h", i, got[i], exp_b[i]); end
    end
    total++; if (stall_bad != 0) begin bad++; $display("FAIL stall_hold got=%0d unstable cycles want=0", stall_bad); end
    total++; if (done_cs.size() != 1) begin bad++; $display("FAIL stall_done_pulses got=%0d want=1", done_cs.size()); end
  endtask

  task automatic test_start_spam();
    fill_rf(1'b0);
    build_exp();
    run_dump(2, 1'b1, 1);
    total++; if (got.size() != 128) begin bad++; $display("FAIL spam_count got=%0d want=128", got.size()); end
    for (int i = 0; i < got.size() && i < 128; i++) begin
      total++; if (got[i] !== exp_b[i]) begin bad++; $display("FAIL spam_byte[%0d] got=%h want=%h", i, got[i], exp_b[i]); end
    end
    total++; if (stall_bad != 0) begin bad++; $display("FAIL spam_hold got=%0d unstable cycles want=0", stall_bad); end
    total++; if (done_cs.size() != 1) begin bad++; $display("FAIL spam_done_pulses got=%0d want=1", done_cs.size()); end
  endtask

  task automatic test_reset_abort();
    int cnt;
    int leaks;
    logic pre_valid;
    fill_rf(1'b0);
    cnt = 0;
    @(negedge clk);
    i_start = 1'b1;
    for (int c = 0; c < MAXC; c++) begin
      @(negedge clk);
      i_start = 1'b0;
      bus.tx_ready = 1'b1;
      if (bus.tx_valid === 1'b1) cnt++;
      if (cnt == 37) break;
    end
    total++; if (cnt != 37) begin bad++; $display("FAIL abort_reach got=%0d bytes want=37", cnt); end
    @(posedge clk);
    #2;
    pre_valid = bus.tx_valid;
    i_rst = 1'b1;
    #1;
    total++; if (pre_valid !== 1'b1) begin bad++; $display("FAIL abort_pre_valid got=%b want=1", pre_valid); end
    total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL abort_valid got=%b want=0", bus.tx_valid); end
    total++; if (bus.tx_data !== 8'h00) begin bad++; $display("FAIL abort_data got=%h want=00", bus.tx_data); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", o_busy); end
    total++; if (bus.rf_addr !== 5'd0) begin bad++; $display("FAIL abort_addr got=%0d want=0", bus.rf_addr); end
    @(negedge clk);
    @(negedge clk);
    i_rst = 1'b0;
    leaks = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.tx_valid !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) leaks++;
    end
    bus.tx_ready = 1'b0;
    total++; if (leaks != 0) begin bad++; $display("FAIL abort_no_resume got=%0d active cycles want=0", leaks); end
    build_exp();
    run_dump(0, 1'b0, 1);
    total++; if (got.size() != 128) begin bad++; $display("FAIL abort_redump_count got=%0d want=128", got.size()); end
    for (int i = 0; i < got.size() && i < 128; i++) begin
      total++; if (got[i] !== exp_b[i]) begin bad++; $display("FAIL abort_byte[%0d] got=%h want=%h", i, got[i], exp_b[i]); end
    end
    total++; if (done_cs.size() != 1) begin bad++; $display("FAIL abort_done_pulses got=%0d want=1", done_cs.size()); end
  endtask

  task automatic test_small();
    logic [7:0] e16[$];
    logic [7:0] g16[$];
    logic [4:0] a16[$];
    int dc, lh, nd;
    rf16[0] = 16'h0;
    for (int n = 1; n < 4; n++) rf16[n] = 16'($urandom);
    for (int r = 0; r < 4; r++)
      for (int b = 0; b < 2; b++) e16.push_back(8'((rf16[r] >> (8 * b)) & 16'hFF));
    dc = -1; lh = -1; nd = 0;
    @(negedge clk);
    start16 = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      start16 = 1'b0;
      bus16.tx_ready = 1'b1;
      if (done16 === 1'b1) begin nd++; dc = c; end
      if (bus16.tx_valid === 1'b1) begin
        g16.push_back(bus16.tx_data);
        a16.push_back(bus16.rf_addr);
        lh = c;
      end
      if (dc >= 0 && c >= dc + 3) break;
    end
    bus16.tx_ready = 1'b0;
    total++; if (g16.size() != 8) begin bad++; $display("FAIL small_count got=%0d want=8", g16.size()); end
    for (int i = 0; i < g16.size() && i < 8; i++) begin
      total++; if (g16[i] !== e16[i]) begin bad++; $display("FAIL small_byte[%0d] got=%h want=%h", i, g16[i], e16[i]); end
      total++; if (a16[i] !== 5'(i / 2)) begin bad++; $display("FAIL small_addr[%0d] got=%0d want=%0d", i, a16[i], i / 2); end
    end
    total++; if (nd != 1) begin bad++; $display("FAIL small_done_pulses got=%0d want=1", nd); end
    total++; if (dc != lh + 1 || dc != 12) begin bad++; $display("FAIL small_done_cycle got=%0d want=12 (last hs %0d)", dc, lh); end
    total++; if (busy16 !== 1'b0) begin bad++; $display("FAIL small_busy_after got=%b want=0", busy16); end
  endtask

  task automatic test_back_to_back();
    int d0, d1;
    fill_rf(1'b0);
    build_exp();
    run_dump(0, 1'b0, 2);
    d0 = (done_cs.size() > 0) ? done_cs[0] : 0;
    d1 = (done_cs.size() > 1) ? done_cs[1] : 0;
    total++; if (done_cs.size() != 2) begin bad++; $display("FAIL b2b_done_pulses got=%0d want=2", done_cs.size()); end
    total++; if (got.size() != 256) begin bad++; $display("FAIL b2b_count got=%0d want=256", got.size()); end
    for (int i = 0; i < got.size() && i < 256; i++) begin
      total++; if (got[i] !== exp_b[i % 128]) begin bad++; $display("FAIL b2b_byte[%0d] got=%h want=%h", i, got[i], exp_b[i % 128]); end
    end
    total++; if (busy_tr[d0+1] !== 1'b0) begin bad++; $display("FAIL b2b_idle_gap got=%b want=0", busy_tr[d0+1]); end
    total++; if (busy_tr[d0+2] !== 1'b1) begin bad++; $display("FAIL b2b_restart got=%b want=1", busy_tr[d0+2]); end
    total++; if (d1 != d0 + 162) begin bad++; $display("FAIL b2b_second_done got=%0d want=%0d", d1, d0 + 162); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_start_spam();
    test_reset_abort();
    test_small();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
